// File: rtl/draw_address_gen_pkg.sv
// Shared constants for the rectangle address generator: region select codes,
// per-region sizes and FSM state encodings.
package draw_address_gen_pkg;

  localparam logic [1:0] MODE_FULL   = 2'b00;
  localparam logic [1:0] MODE_CANVAS = 2'b01;
  localparam logic [1:0] MODE_ANSWER = 2'b10;
  localparam logic [1:0] MODE_CUSTOM = 2'b11;

  localparam int FULL_W   = 160;
  localparam int FULL_H   = 120;
  localparam int CANVAS_W = 115;
  localparam int CANVAS_H = 70;
  localparam int ANSWER_W = 21;
  localparam int ANSWER_H = 17;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SWEEP = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

endpackage

// File: rtl/draw_address_gen_raster_counter.sv
// Raster position counter: x runs 0..w-1 inside y 0..h-1, wrapping to (0,0)
// after the last position so it always rests at the origin between sweeps.
module raster_counter #(
  parameter int X_W = 8,
  parameter int Y_W = 7
) (
  input  logic           clock,
  input  logic           resetn,
  input  logic [X_W-1:0] w,
  input  logic [Y_W-1:0] h,
  input  logic           advance,
  output logic [X_W-1:0] xpos,
  output logic [Y_W-1:0] ypos,
  output logic           last
);

  logic [X_W-1:0] xpos_q, xpos_d;
  logic [Y_W-1:0] ypos_q, ypos_d;
  logic           x_end, y_end;

  // NOTE: every variable assigned here gets a default first, so no path can leave one unassigned and infer a latch.
  always_comb begin
    x_end  = (xpos_q == w - X_W'(1));
    y_end  = (ypos_q == h - Y_W'(1));
    last   = x_end && y_end;
    xpos_d = xpos_q;
    ypos_d = ypos_q;
    if (advance) begin
      if (x_end) begin
        xpos_d = '0;
        ypos_d = y_end ? '0 : ypos_q + Y_W'(1);
      end else begin
        xpos_d = xpos_q + X_W'(1);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      xpos_q <= '0;
      ypos_q <= '0;
    end else begin
      xpos_q <= xpos_d;
      ypos_q <= ypos_d;
    end
  end

  assign xpos = xpos_q;
  assign ypos = ypos_q;

endmodule

// File: rtl/draw_address_gen.sv
// Sweeps a rectangle in raster order and presents each on-screen pixel address
// {y,x} on a registered valid/ready port; off-screen pixels are skipped silently.
module draw_address_gen
  import draw_address_gen_pkg::*;
#(
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic               start,
  input  logic [1:0]         mode,
  input  logic [X_W-1:0]     startX,
  input  logic [Y_W-1:0]     startY,
  input  logic [X_W-1:0]     width,
  input  logic [Y_W-1:0]     height,
  input  logic               ready,
  output logic [X_W+Y_W-1:0] out,
  output logic               valid,
  output logic               busy,
  output logic               done
);

  logic [1:0]         state_q, state_d;
  logic [X_W-1:0]     org_x_q, org_x_d, size_w_q, size_w_d;
  logic [Y_W-1:0]     org_y_q, org_y_d, size_h_q, size_h_d;
  logic [X_W+Y_W-1:0] out_q, out_d;
  logic               valid_q, valid_d;
  logic               issued_all_q, issued_all_d;

  logic [X_W-1:0] req_x, req_w, cur_x, cur_w, xpos;
  logic [Y_W-1:0] req_y, req_h, cur_y, cur_h, ypos;
  logic [X_W:0]   x_sum;
  logic [Y_W:0]   y_sum;
  logic           in_idle, accept, zero_size, on_screen, slot_free, compute, last;

  raster_counter #(.X_W(X_W), .Y_W(Y_W)) u_raster (
    .clock   (clock),
    .resetn  (resetn),
    .w       (cur_w),
    .h       (cur_h),
    .advance (compute),
    .xpos    (xpos),
    .ypos    (ypos),
    .last    (last)
  );

  always_comb begin
    req_x = startX;
    req_y = startY;
    req_w = width;
    req_h = height;
    case (mode)
      MODE_FULL:   begin req_x = '0; req_y = '0; req_w = X_W'(FULL_W); req_h = Y_W'(FULL_H); end
      MODE_CANVAS: begin req_w = X_W'(CANVAS_W); req_h = Y_W'(CANVAS_H); end
      MODE_ANSWER: begin req_w = X_W'(ANSWER_W); req_h = Y_W'(ANSWER_H); end
      default:     ;
    endcase
  end

  // In the accept cycle the first pixel is computed straight from the inputs,
  // so it is registered on the same edge that leaves IDLE.
  always_comb begin
    in_idle   = (state_q == ST_IDLE);
    accept    = in_idle && start;
    zero_size = (req_w == '0) || (req_h == '0);
    cur_x     = in_idle ? req_x : org_x_q;
    cur_y     = in_idle ? req_y : org_y_q;
    cur_w     = in_idle ? req_w : size_w_q;
    cur_h     = in_idle ? req_h : size_h_q;
    x_sum     = {1'b0, cur_x} + {1'b0, xpos};
    y_sum     = {1'b0, cur_y} + {1'b0, ypos};
    on_screen = (x_sum < (X_W+1)'(SCREEN_W)) && (y_sum < (Y_W+1)'(SCREEN_H));
    slot_free = !valid_q || ready;
    compute   = accept ? !zero_size
                       : ((state_q == ST_SWEEP) && slot_free && !issued_all_q);
  end

  always_comb begin
    state_d      = state_q;
    org_x_d      = org_x_q;
    org_y_d      = org_y_q;
    size_w_d     = size_w_q;
    size_h_d     = size_h_q;
    out_d        = out_q;
    valid_d      = valid_q && !ready;
    issued_all_d = issued_all_q;

    if (compute) begin
      issued_all_d = last;
      if (on_screen) begin
        out_d   = {y_sum[Y_W-1:0], x_sum[X_W-1:0]};
        valid_d = 1'b1;
      end
    end

    case (state_q)
      ST_IDLE: if (accept) begin
        org_x_d  = req_x;
        org_y_d  = req_y;
        size_w_d = req_w;
        size_h_d = req_h;
        state_d  = zero_size ? ST_DONE : ST_SWEEP;
      end
      // Off-screen last pixel retires in its compute cycle; on-screen waits for ready.
      ST_SWEEP: if (slot_free && (issued_all_q || (compute && last && !on_screen)))
        state_d = ST_DONE;
      default: begin
        state_d      = ST_IDLE;
        issued_all_d = 1'b0;
      end
    endcase
  end

  // NOTE: the async reset clears every flop here, including latched origin and size, so a fresh start never sees stale state.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q      <= ST_IDLE;
      org_x_q      <= '0;
      org_y_q      <= '0;
      size_w_q     <= '0;
      size_h_q     <= '0;
      out_q        <= '0;
      valid_q      <= 1'b0;
      issued_all_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      org_x_q      <= org_x_d;
      org_y_q      <= org_y_d;
      size_w_q     <= size_w_d;
      size_h_q     <= size_h_d;
      out_q        <= out_d;
      valid_q      <= valid_d;
      issued_all_q <= issued_all_d;
    end
  end

  assign out   = out_q;
  assign valid = valid_q;
  assign busy  = (state_q != ST_IDLE);
  assign done  = (state_q == ST_DONE);

endmodule

// File: doc/draw_address_gen.md
DRAW_ADDRESS_GEN -- requirements
Module: draw_address_gen

Interface
REQ-001 Parameter X_W, default 8, x coordinate width in bits.
REQ-002 Parameter Y_W, default 7, y coordinate width in bits.
REQ-003 Parameter SCREEN_W, default 160, visible columns.
REQ-004 Parameter SCREEN_H, default 120, visible rows.
REQ-005 Port clock  input  1  sole clock, all state on rising edge.
REQ-006 Port resetn  input  1  asynchronous, active-low reset.
REQ-007 Port start  input  1  request one rectangle sweep; sampled only in IDLE.
REQ-008 Port mode  input  2  region select: 00 fullscreen, 01 canvas, 10 answer, 11 custom.
REQ-009 Port startX  input  X_W  rectangle origin x, latched at accepted start.
REQ-010 Port startY  input  Y_W  rectangle origin y, latched at accepted start.
REQ-011 Port width  input  X_W  custom width, mode 11 only, latched at accepted start.
REQ-012 Port height  input  Y_W  custom height, mode 11 only, latched at accepted start.
REQ-013 Port ready  input  1  downstream (VGA write) accepts current pixel this cycle.
REQ-014 Port out  output  X_W+Y_W  pixel address {y,x}.
REQ-015 Port valid  output  1  out holds an on-screen pixel awaiting ready.
REQ-016 Port busy  output  1  sweep in progress (state not IDLE).
REQ-017 Port done  output  1  one-cycle pulse after final pixel of a sweep.

Function
REQ-018 FSM states IDLE, SWEEP, DONE; IDLE->SWEEP on start; SWEEP->DONE after last pixel retires; DONE->IDLE unconditionally next cycle.
REQ-019 Region size: fullscreen 160x120 with origin forced to (0,0); canvas 115x70; answer 21x17; custom width x height from ports.
REQ-020 Custom width or height of 0: start accepted, SWEEP skipped, DONE entered the next cycle, no valid issued.
REQ-021 Sweep order raster: Xpos 0..W-1 inner, Ypos 0..H-1 outer; out = {originY+Ypos, originX+Xpos}, sum computed at X_W+1/Y_W+1 bits before range check.
REQ-022 Pixel retires when valid&&ready, or in the same cycle it is computed if off-screen (x>=SCREEN_W or y>=SCREEN_H); off-screen pixels never assert valid.
REQ-023 out and valid are registered; first valid appears 1 cycle after start accepted; with ready held high, one pixel per cycle, W*H+1 cycles start-to-done for fully on-screen region.
REQ-024 valid held and out stable while ready low (no pixel dropped or repeated).
REQ-025 start during SWEEP or DONE ignored; start and last-pixel retire in same cycle: start ignored.
REQ-026 Inputs other than ready have no effect outside the start-accept cycle.

Reset
REQ-027 resetn low forces IDLE, out=0, valid=0, busy=0, done=0, counters and latched origin/size cleared, immediately and regardless of clock.
REQ-028 Reset mid-sweep abandons the sweep; no done pulse; first start after release begins a fresh sweep.

Structure
REQ-029 Shared package holds mode encodings, per-mode region sizes (160x120, 115x70, 21x17) and FSM state encodings.
REQ-030 One sub-module, raster_counter: W/H-bounded Xpos/Ypos counter with advance input and last output.
REQ-031 Total RTL 120-400 lines, no multipliers, no dividers.

Verification
REQ-032 mode 10, startX=10, startY=5, ready=1 -> 357 valid cycles, first out {5,10}, last {21,30}, done on cycle 358.
REQ-033 mode 01, startX=100, startY=80, ready=1 -> only pixels with x<160, y<120 emitted (60x40=2400), done after 115x70 sweep.
REQ-034 mode 10 sweep, ready toggled 1-0-0-1 -> out frozen during low, no duplicate/missing address in scoreboard.
REQ-035 mode 11, width=0 -> busy 1 cycle, done pulse, valid never high.
REQ-036 resetn low at pixel 50 of canvas sweep -> outputs zero asynchronously, no done; new start after release gives first out = new origin.
REQ-037 start re-pulsed during sweep -> ignored, pixel count unchanged.
